// File: rtl/stack_alu_pkg.sv
// stack_alu_pkg: opcodes, FSM state type and saturation helper for stack_alu_mc
package stack_alu_pkg;
    localparam int MAXW = 64;
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_POP  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_DUP  = 4'd6;
    localparam logic [3:0] OP_SWAP = 4'd7;
    localparam logic [3:0] OP_CLR  = 4'd8;
    typedef enum logic {IDLE, MUL_BUSY} state_t;
    // Exact value x reduced to w bits; returns {overflow, result}. Result is clamped when sat.
    function automatic logic [MAXW:0] sat_fn(input logic signed [2*MAXW-1:0] x, input int w, input logic sat);
        logic signed [2*MAXW-1:0] mx, mn, r;
        logic ovf;
        mx  = (128'sd1 <<< (w - 1)) - 128'sd1;
        mn  = -mx - 128'sd1;
        ovf = (x > mx) || (x < mn);
        r   = (ovf && sat) ? (x[2*MAXW-1] ? mn : mx) : x;
        return {ovf, r[MAXW-1:0]};
    endfunction
endpackage

// File: rtl/stack_alu_mul.sv
// stack_alu_mul: latched-operand multiplier completing MUL_LAT cycles after start
//   clk, rst (async, active-high); start latches a/b; done pulses in the final
//   busy cycle alongside product (W bits, wrapped or saturated) and ovf.
module stack_alu_mul import stack_alu_pkg::*; #(
    parameter int W       = 32,
    parameter int MUL_LAT = 3,
    parameter int SAT     = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] product,
    output logic         ovf,
    output logic         done
);
    localparam int CW = $clog2(MUL_LAT + 1);
    logic signed [W-1:0]   ra, rb;
    logic signed [2*W-1:0] p;
    logic [MAXW:0]         s;
    logic [CW-1:0]         cnt;
    logic                  busy;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            ra   <= '0;
            rb   <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(1);
            ra   <= a;
            rb   <= b;
        end else if (done) begin
            busy <= 1'b0;
        end else if (busy) begin
            cnt  <= cnt + CW'(1);
        end
    end
    // cnt counts cycles since the accept edge, so done lines up with edge T+MUL_LAT
    assign done    = busy && (cnt == CW'(MUL_LAT));
    assign p       = ra * rb;
    assign s       = sat_fn((2*MAXW)'(p), W, SAT != 0);
    assign product = s[W-1:0];
    assign ovf     = s[MAXW];
endmodule

// File: rtl/stack_alu_mc.sv
// stack_alu_mc: multi-cycle stack-machine ALU with valid/ready command interface
//   clk, rst (async, active-high); in_valid/in_ready/opcode/in_data command;
//   out_valid pulse with out_data, overflow, err; sp = stack occupancy.
module stack_alu_mc import stack_alu_pkg::*; #(
    parameter int W       = 32,
    parameter int DEPTH   = 32,
    parameter int MUL_LAT = 3,
    parameter int SAT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 opcode,
    input  logic [W-1:0]               in_data,
    output logic                       out_valid,
    output logic [W-1:0]               out_data,
    output logic                       overflow,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] sp
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);
    logic [W-1:0]    mem [DEPTH];
    state_t          state, nxt;
    logic [AW-1:0]   ia, ib, ip;
    logic [W-1:0]    a, b, r_as, mul_p;
    logic signed [W:0] ex;
    logic [MAXW:0]   s_as;
    logic            acc, ok, has1, has2, not_full, is_as, mul_start, mul_done, mul_ovf;
    assign in_ready  = (state == IDLE);
    assign acc       = in_valid && in_ready;
    assign ip        = AW'(sp);
    assign ia        = AW'(sp - SPW'(1));
    assign ib        = AW'(sp - SPW'(2));
    assign a         = mem[ia];
    assign b         = mem[ib];
    assign has1      = sp >= SPW'(1);
    assign has2      = sp >= SPW'(2);
    assign not_full  = sp < SPW'(DEPTH);
    assign is_as     = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign ok        = (opcode == OP_NOP || opcode == OP_CLR) ? 1'b1 :
                       (opcode == OP_PUSH) ? not_full :
                       (opcode == OP_POP)  ? has1 :
                       (opcode == OP_DUP)  ? has1 && not_full :
                       (is_as || opcode == OP_MUL || opcode == OP_SWAP) ? has2 : 1'b0;
    assign mul_start = acc && ok && (opcode == OP_MUL);
    // W+1 bits hold any B+A or B-A exactly
    assign ex        = (opcode == OP_SUB) ? $signed({b[W-1], b}) - $signed({a[W-1], a})
                                          : $signed({b[W-1], b}) + $signed({a[W-1], a});
    assign s_as      = sat_fn((2*MAXW)'(ex), W, SAT != 0);
    assign r_as      = s_as[W-1:0];
    stack_alu_mul #(.W(W), .MUL_LAT(MUL_LAT), .SAT(SAT)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .product (mul_p),
        .ovf     (mul_ovf),
        .done    (mul_done)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    always_comb begin
        nxt = state;
        nxt = (state == IDLE) ? (mul_start ? MUL_BUSY : IDLE) : (mul_done ? IDLE : MUL_BUSY);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= mul_done || (acc && !mul_start);
            if (mul_done) begin
                sp       <= sp - SPW'(1);
                out_data <= mul_p;
                overflow <= mul_ovf;
                err      <= 1'b0;
            end else if (acc && !mul_start) begin
                err      <= !ok;
                overflow <= ok && is_as && s_as[MAXW];
                sp       <= !ok ? sp :
                            (opcode == OP_PUSH || opcode == OP_DUP) ? sp + SPW'(1) :
                            (opcode == OP_POP || is_as) ? sp - SPW'(1) :
                            (opcode == OP_CLR) ? '0 : sp;
                out_data <= (ok && opcode == OP_POP) ? a : (ok && is_as) ? r_as : out_data;
            end
        end
    end
    // Stack RAM has no reset; sp alone defines which entries are live
    always_ff @(posedge clk) begin
        if (mul_done) begin
            mem[ib] <= mul_p;
        end else if (acc && ok) begin
            if (opcode == OP_PUSH) mem[ip] <= in_data;
            if (opcode == OP_DUP)  mem[ip] <= a;
            if (is_as)             mem[ib] <= r_as;
            if (opcode == OP_SWAP) begin
                mem[ia] <= b;
                mem[ib] <= a;
            end
        end
    end
endmodule

// File: tb/tb_stack_alu_mc.sv
// tb_stack_alu_mc: directed self-checking bench for stack_alu_mc (W=8, DEPTH=4, MUL_LAT=3)
module tb_stack_alu_mc;
    import stack_alu_pkg::*;
    logic              clk = 1'b0;
    logic              rst, in_valid;
    logic [3:0]        opcode;
    logic [7:0]        in_data;
    logic              rdy0, rdy1, ov0, ov1, vf0, vf1, er0, er1;
    logic signed [7:0] od0, od1;
    logic [2:0]        sp0, sp1;
    int                passed = 0;
    int                total = 0;
    always #5 clk = ~clk;
    stack_alu_mc #(.W(8), .DEPTH(4), .MUL_LAT(3), .SAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .opcode(opcode),
        .in_data(in_data), .out_valid(vf0), .out_data(od0), .overflow(ov0), .err(er0), .sp(sp0)
    );
    stack_alu_mc #(.W(8), .DEPTH(4), .MUL_LAT(3), .SAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .opcode(opcode),
        .in_data(in_data), .out_valid(vf1), .out_data(od1), .overflow(ov1), .err(er1), .sp(sp1)
    );
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    // Present a command, wait (bounded) for in_ready, return just after the accept edge
    task automatic send(input logic [3:0] op, input int d);
        int n = 0;
        in_valid = 1'b1;
        opcode   = op;
        in_data  = 8'(d);
        while (!rdy0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_accept", int'(rdy0), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask
    initial begin
        int pulses;
        rst = 1'b1; in_valid = 1'b0; opcode = OP_NOP; in_data = '0;
        #12;
        check("rst_sp", sp0, 0);
        check("rst_out_data", od0, 0);
        check("rst_out_valid", vf0, 0);
        check("rst_err", er0, 0);
        check("rst_in_ready", rdy0, 1);
        @(posedge clk); #1 rst = 1'b0;
        // ADD overflow: wrap vs saturate
        send(OP_PUSH, 100);
        send(OP_PUSH, 50);
        send(OP_ADD, 0);
        check("add_wrap_data", od0, -106);
        check("add_wrap_ovf", ov0, 1);
        check("add_sat_data", od1, 127);
        check("add_sat_ovf", ov1, 1);
        check("add_sp", sp0, 1);
        check("add_valid", vf0, 1);
        @(posedge clk); #1;
        check("valid_one_cycle", vf0, 0);
        send(OP_CLR, 0);
        check("clr_sp", sp0, 0);
        check("clr_keeps_data", od0, -106);
        // SUB then POP
        send(OP_PUSH, 5);
        send(OP_PUSH, 7);
        send(OP_SUB, 0);
        check("sub_data", od0, -2);
        check("sub_ovf", ov0, 0);
        check("sub_sp", sp0, 1);
        send(OP_POP, 0);
        check("pop_data", od0, -2);
        check("pop_sp", sp0, 0);
        // Multi-cycle MUL with a command held while busy; -160 overflows 8 bits
        send(OP_PUSH, -16);
        send(OP_PUSH, 10);
        send(OP_MUL, 0);
        check("mul_T_ready", rdy0, 0);
        check("mul_T_valid", vf0, 0);
        in_valid = 1'b1; opcode = OP_PUSH; in_data = 8'd33;
        @(posedge clk); #1;
        check("mul_T1_ready", rdy0, 0);
        @(posedge clk); #1;
        check("mul_T2_ready", rdy0, 0);
        check("mul_T2_valid", vf0, 0);
        check("mul_T2_sp", sp0, 2);
        @(posedge clk); #1;
        check("mul_T3_valid", vf0, 1);
        check("mul_wrap_data", od0, 96);
        check("mul_ovf", ov0, 1);
        check("mul_sat_data", od1, -128);
        check("mul_sp", sp0, 1);
        check("mul_T3_ready", rdy0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("held_push_valid", vf0, 1);
        check("held_push_sp", sp0, 2);
        check("held_push_keeps_data", od0, 96);
        send(OP_POP, 0);
        check("held_push_value", od0, 33);
        send(OP_CLR, 0);
        // MUL with one operand is an immediate error
        send(OP_PUSH, 2);
        send(OP_MUL, 0);
        check("mul_short_valid", vf0, 1);
        check("mul_short_err", er0, 1);
        check("mul_short_ready", rdy0, 1);
        check("mul_short_sp", sp0, 1);
        send(OP_CLR, 0);
        // Full / empty boundaries and illegal opcode
        for (int i = 1; i <= 4; i++) send(OP_PUSH, i);
        check("full_sp", sp0, 4);
        check("full_err", er0, 0);
        send(OP_PUSH, 5);
        check("push_full_err", er0, 1);
        check("push_full_sp", sp0, 4);
        send(OP_DUP, 0);
        check("dup_full_err", er0, 1);
        for (int i = 4; i >= 1; i--) begin
            send(OP_POP, 0);
            check("drain_data", od0, i);
        end
        send(OP_POP, 0);
        check("pop_empty_err", er0, 1);
        check("pop_empty_ovf", ov0, 0);
        check("pop_empty_sp", sp0, 0);
        check("pop_empty_data", od0, 1);
        send(4'd12, 0);
        check("illegal_err", er0, 1);
        check("illegal_valid", vf0, 1);
        send(OP_NOP, 0);
        check("nop_err", er0, 0);
        // SWAP / DUP
        send(OP_PUSH, 3);
        send(OP_PUSH, 9);
        send(OP_SWAP, 0);
        send(OP_POP, 0);
        check("swap_pop", od0, 3);
        send(OP_DUP, 0);
        check("dup_sp", sp0, 2);
        send(OP_POP, 0);
        check("dup_pop1", od0, 9);
        send(OP_POP, 0);
        check("dup_pop2", od0, 9);
        check("dup_end_sp", sp0, 0);
        send(OP_PUSH, 1);
        send(OP_CLR, 0);
        check("clr_end_sp", sp0, 0);
        // Reset two cycles into a MUL
        send(OP_PUSH, 2);
        send(OP_PUSH, 3);
        send(OP_MUL, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_sp", sp0, 0);
        check("mid_rst_ready", rdy0, 1);
        check("mid_rst_valid", vf0, 0);
        @(posedge clk); #1 rst = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            pulses += int'(vf0);
        end
        check("mid_rst_no_pulse", pulses, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
